// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder that produces one sum bit per clock,
// LSB first, then presents the registered sum, carry-out and signed overflow
// together with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Bit index counter must hold 0..WIDTH-1; sized from WIDTH+1 so WIDTH=1 still gets one bit.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] idx_q;
  logic             carry_q;
  logic             carry_d;
  logic             sumBit;
  logic             lastBit;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  // One full-adder slice on the current LSBs; the partial sum fills in from the MSB end.
  always_comb begin
    sumBit  = opA_q[0] ^ opB_q[0] ^ carry_q;
    carry_d = (opA_q[0] & opB_q[0]) | (carry_q & (opA_q[0] ^ opB_q[0]));
    acc_d   = acc_q >> 1;
    acc_d[WIDTH-1] = sumBit;
    lastBit = (idx_q == LAST_IDX);
  end

  // Control FSM plus datapath registers; results are only written on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            opA_q   <= a;
            opB_q   <= b;
            carry_q <= cin;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          opA_q   <= opA_q >> 1;
          opB_q   <= opB_q >> 1;
          carry_q <= carry_d;
          acc_q   <= acc_d;
          idx_q   <= idx_q + CNT_W'(1);
          if (lastBit) begin
            sum_q   <= acc_d;
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
